alu_acc_sequencer: RTL and testbench
====================================

ALU_ACC_SEQUENCER -- requirements
Module: alu_acc_sequencer

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 cmd_valid  input  1  command present.
REQ-004 cmd_ready  output  1  block can accept a command.
REQ-005 cmd_op  input  4  ALU operation code (0000 add ... 1111 equal, 8-bit ALU encoding).
REQ-006 cmd_operand  input  8  second operand, or load value.
REQ-007 cmd_load  input  1  1 = load cmd_operand into accumulator; no ALU operation.
REQ-008 operand_a  output  8  to ALU; always equals acc register.
REQ-009 operand_b  output  8  to ALU; always equals latched operand register.
REQ-010 operation  output  4  to ALU; always equals latched op register.
REQ-011 result  input  8  combinational ALU result.
REQ-012 carry_out  input  1  ALU 9-bit add carry.
REQ-013 acc  output  8  accumulator.
REQ-014 flags  output  5  {S,Z,AC,P,CY}.
REQ-015 done  output  1  one-cycle pulse; command retired.
REQ-016 err  output  1  one-cycle pulse with done; divide by zero.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, DONE; cmd_ready = 1 only in IDLE.
REQ-018 Accept on the edge with cmd_valid & cmd_ready; latch cmd_op, cmd_operand, cmd_load; go to ISSUE.
REQ-019 ISSUE lasts one cycle; the ALU evaluates combinationally; on the exit edge acc/flags update; go to DONE.
REQ-020 DONE lasts one cycle with done=1; then IDLE. Throughput: one command per 3 cycles. cmd_valid is ignored outside IDLE.
REQ-021 Load: acc <= latched operand; flags unchanged.
REQ-022 Ops 0000-1101 (except divide-by-zero): acc <= result; S=result[7]; Z=(result==0); P=1 if result has an even count of ones.
REQ-023 AC: add = carry out of bit 3 of acc[3:0]+operand[3:0]; all other ops = 0.
REQ-024 CY by op:
- add = carry_out
- sub = 1 if acc < operand (borrow)
- 0100, 0110 = acc[7]
- 0101, 0111 = acc[0]
- mul = 1 if the 16-bit product > 8'hFF
- all others = 0
REQ-025 Compare ops 1110, 1111: acc unchanged; Z <= result[0]; S, AC, P, CY unchanged.
REQ-026 Divide (0011) with operand 0: acc and flags unchanged; err=1 during DONE.
REQ-027 CY, AC and the compare condition SHALL use the pre-update acc value.
REQ-028 operand_a/operand_b/operation SHALL be register outputs, stable for the whole ISSUE cycle.

Reset
REQ-029 On rst_n low, immediately: state=IDLE, acc=0, flags=0, operand/op registers=0, done=0, err=0, cmd_ready=1 after release.
REQ-030 Reset in ISSUE or DONE drops the command; no acc/flag update and no done pulse occur for it.

Verification
REQ-031 Reset, then load 0x7F -> done after 3 cycles; acc=0x7F, flags=00000.
REQ-032 acc=0x7F, add 0x01 -> acc=0x80, S=1, Z=0, AC=1, P=0, CY=0.
REQ-033 acc=0xFF, add 0x01 -> acc=0x00, S=0, Z=1, AC=1, P=1, CY=1.
REQ-034 acc=0x05, sub 0x07 -> acc=0xFE, S=1, Z=0, AC=0, P=0, CY=1.
REQ-035 acc=0x10, divide by 0x00 -> err=1 and done=1 in the same cycle; acc=0x10; flags unchanged.
REQ-036 acc=0x42, op 1111 with 0x42 -> acc=0x42, Z=1; then assert rst_n low during ISSUE of an add -> acc=0, no done pulse.

Source files
------------

// File: rtl/alu_acc_sequencer.sv
// rtl/alu_acc_sequencer.sv - accumulator sequencer driving an external combinational 8-bit ALU
module alu_acc_sequencer (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_cmd_valid,
   output logic       o_cmd_ready,
   input  logic [3:0] i_cmd_op,
   input  logic [7:0] i_cmd_operand,
   input  logic       i_cmd_load,
   output logic [7:0] o_operand_a,
   output logic [7:0] o_operand_b,
   output logic [3:0] o_operation,
   input  logic [7:0] i_result,
   input  logic       i_carry_out,
   output logic [7:0] o_acc,
   output logic [4:0] o_flags,
   output logic       o_done,
   output logic       o_err
);

   // Flag bit positions within {S,Z,AC,P,CY}
   localparam int F_S  = 4;
   localparam int F_Z  = 3;
   localparam int F_AC = 2;
   localparam int F_P  = 1;
   localparam int F_CY = 0;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_MUL = 4'b0010;
   localparam logic [3:0] OP_DIV = 4'b0011;
   localparam logic [3:0] OP_SL0 = 4'b0100;
   localparam logic [3:0] OP_SR0 = 4'b0101;
   localparam logic [3:0] OP_SL1 = 4'b0110;
   localparam logic [3:0] OP_SR1 = 4'b0111;
   localparam logic [3:0] OP_CMP0 = 4'b1110;
   localparam logic [3:0] OP_CMP1 = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic [7:0]  r_acc;
   logic [4:0]  r_flags;
   logic [3:0]  r_op;
   logic [7:0]  r_operand;
   logic        r_load;

   logic [7:0]  w_acc_next;
   logic [4:0]  w_flags_next;
   logic [4:0]  w_nib_sum;
   logic [15:0] w_product;
   logic        w_div_zero;
   logic        w_accept;

   assign w_accept    = (r_state == ST_IDLE) && i_cmd_valid;
   assign w_nib_sum   = {1'b0, r_acc[3:0]} + {1'b0, r_operand[3:0]};
   assign w_product   = 16'(r_acc) * 16'(r_operand);
   assign w_div_zero  = !r_load && (r_op == OP_DIV) && (r_operand == 8'h00);

   assign o_operand_a = r_acc;
   assign o_operand_b = r_operand;
   assign o_operation = r_op;
   assign o_acc       = r_acc;
   assign o_flags     = r_flags;

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state: IDLE waits for a command, ISSUE and DONE each last one cycle
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (i_cmd_valid) w_next_state = ST_ISSUE;
         ST_ISSUE: w_next_state = ST_DONE;
         ST_DONE:  w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // Outputs decoded from state; err reuses the still-latched command during DONE
   always_comb begin
      o_cmd_ready = 1'b0;
      o_done      = 1'b0;
      o_err       = 1'b0;
      case (r_state)
         ST_IDLE: o_cmd_ready = 1'b1;
         ST_DONE: begin
            o_done = 1'b1;
            o_err  = w_div_zero;
         end
         default: ;
      endcase
   end

   // Command capture; registers hold through ISSUE and DONE so the ALU sees stable inputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_op      <= 4'h0;
         r_operand <= 8'h00;
         r_load    <= 1'b0;
      end else if (w_accept) begin
         r_op      <= i_cmd_op;
         r_operand <= i_cmd_operand;
         r_load    <= i_cmd_load;
      end
   end

   // Retire computation: all flag terms use the acc value before this update
   always_comb begin
      w_acc_next   = r_acc;
      w_flags_next = r_flags;
      if (r_load) begin
         w_acc_next = r_operand;
      end else if ((r_op == OP_CMP0) || (r_op == OP_CMP1)) begin
         w_flags_next[F_Z] = i_result[0];
      end else if (!w_div_zero) begin
         w_acc_next         = i_result;
         w_flags_next[F_S]  = i_result[7];
         w_flags_next[F_Z]  = (i_result == 8'h00);
         w_flags_next[F_AC] = (r_op == OP_ADD) ? w_nib_sum[4] : 1'b0;
         w_flags_next[F_P]  = ~^i_result;
         case (r_op)
            OP_ADD:         w_flags_next[F_CY] = i_carry_out;
            OP_SUB:         w_flags_next[F_CY] = (r_acc < r_operand);
            OP_MUL:         w_flags_next[F_CY] = |w_product[15:8];
            OP_SL0, OP_SL1: w_flags_next[F_CY] = r_acc[7];
            OP_SR0, OP_SR1: w_flags_next[F_CY] = r_acc[0];
            default:        w_flags_next[F_CY] = 1'b0;
         endcase
      end
   end

   // Accumulator and flags update on the edge leaving ISSUE
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc   <= 8'h00;
         r_flags <= 5'b00000;
      end else if (r_state == ST_ISSUE) begin
         r_acc   <= w_acc_next;
         r_flags <= w_flags_next;
      end
   end

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// tb/tb_alu_acc_sequencer.sv - randomized self-checking bench for alu_acc_sequencer
module tb_alu_acc_sequencer;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_op;
   logic [7:0] cmd_operand;
   logic       cmd_load;
   logic [7:0] operand_a;
   logic [7:0] operand_b;
   logic [3:0] operation;
   logic [7:0] result;
   logic       carry_out;
   logic [7:0] acc;
   logic [4:0] flags;
   logic       done;
   logic       err;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int         m_acc   = 0;
   logic [4:0] m_flags = 5'b00000;

   alu_acc_sequencer dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_cmd_valid   (cmd_valid),
      .o_cmd_ready   (cmd_ready),
      .i_cmd_op      (cmd_op),
      .i_cmd_operand (cmd_operand),
      .i_cmd_load    (cmd_load),
      .o_operand_a   (operand_a),
      .o_operand_b   (operand_b),
      .o_operation   (operation),
      .i_result      (result),
      .i_carry_out   (carry_out),
      .o_acc         (acc),
      .o_flags       (flags),
      .o_done        (done),
      .o_err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural ALU the sequencer drives
   function automatic logic [7:0] alu_f(input int a, input int b, input int op);
      int r;
      case (op)
         0:  r = a + b;
         1:  r = a - b;
         2:  r = a * b;
         3:  r = (b == 0) ? 255 : a / b;
         4:  r = a * 2;
         5:  r = a / 2;
         6:  r = a * 2 + a / 128;
         7:  r = a / 2 + (a % 2) * 128;
         8:  r = a & b;
         9:  r = a | b;
         10: r = a ^ b;
         11: r = 255 - a;
         12: r = a + 1;
         13: r = a - 1;
         14: r = (a < b) ? 1 : 0;
         default: r = (a == b) ? 1 : 0;
      endcase
      return 8'(r & 255);
   endfunction

   always_comb begin
      result    = alu_f(int'(operand_a), int'(operand_b), int'(operation));
      carry_out = (int'(operand_a) + int'(operand_b)) > 255;
   end

   task automatic send_cmd(input logic [3:0] op, input logic [7:0] operand,
                           input logic load, input logic garbage);
      int         a, b, r;
      logic       exp_err;
      logic       s, z, ac, p, cy;
      logic [7:0] rv;
      a = m_acc;
      b = int'(operand);
      exp_err = 1'b0;
      rv = alu_f(a, b, int'(op));
      r = int'(rv);
      if (load) begin
         m_acc = b;
      end else if (op >= 4'd14) begin
         m_flags[3] = rv[0];
      end else if (op == 4'd3 && b == 0) begin
         exp_err = 1'b1;
      end else begin
         s  = (r >= 128);
         z  = (r == 0);
         ac = (op == 4'd0) && ((a % 16 + b % 16) > 15);
         p  = ($countones(rv) % 2 == 0);
         case (int'(op))
            0:    cy = (a + b) > 255;
            1:    cy = a < b;
            2:    cy = a * b > 255;
            4, 6: cy = a >= 128;
            5, 7: cy = (a % 2) == 1;
            default: cy = 1'b0;
         endcase
         m_acc   = r;
         m_flags = {s, z, ac, p, cy};
      end

      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = op; cmd_operand = operand; cmd_load = load;
      @(posedge clk); #1;
      if (garbage) begin
         cmd_op = 4'($urandom); cmd_operand = 8'($urandom); cmd_load = 1'($urandom);
      end else begin
         cmd_valid = 1'b0;
      end
      #1;
      n_checks++;
      if (cmd_ready !== 1'b0 || done !== 1'b0) begin
         n_fail++; $display("FAIL issue_ctrl: ready=%b done=%b, required 0 0", cmd_ready, done);
      end
      n_checks++;
      if (operand_a !== 8'(a) || operand_b !== operand || operation !== op) begin
         n_fail++;
         $display("FAIL issue_operands: a=%h b=%h op=%h, required %h %h %h",
                  operand_a, operand_b, operation, 8'(a), operand, op);
      end
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b1 || err !== exp_err) begin
         n_fail++; $display("FAIL done_err: done=%b err=%b, required 1 %b", done, err, exp_err);
      end
      n_checks++;
      if (acc !== 8'(m_acc) || flags !== m_flags) begin
         n_fail++;
         $display("FAIL acc_flags op=%h load=%b: acc=%h flags=%b, required %h %b",
                  op, load, acc, flags, 8'(m_acc), m_flags);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      n_checks++;
      if (cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
         n_fail++; $display("FAIL idle_ctrl: ready=%b done=%b err=%b, required 1 0 0", cmd_ready, done, err);
      end
   endtask

   task automatic reset_in_flight(input int phase);
      int saw_done;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 4'd0; cmd_operand = 8'h11; cmd_load = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (phase == 1) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      m_acc = 0; m_flags = 5'b00000;
      n_checks++;
      if (acc !== 8'h00 || flags !== 5'b00000 || done !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_flight%0d: acc=%h flags=%b done=%b err=%b, required 00 00000 0 0",
                  phase, acc, flags, done, err);
      end
      n_checks++;
      if (operand_b !== 8'h00 || operation !== 4'h0) begin
         n_fail++; $display("FAIL reset_regs%0d: b=%h op=%h, required 00 0", phase, operand_b, operation);
      end
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done === 1'b1) saw_done++;
      end
      n_checks++;
      if (saw_done != 0 || cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_drop%0d: done pulses=%0d ready=%b, required 0 1", phase, saw_done, cmd_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_operand = 8'h00; cmd_load = 1'b0;
      #12;
      n_checks++;
      if (acc !== 8'h00 || flags !== 5'b00000 || done !== 1'b0 || err !== 1'b0) begin
         n_fail++; $display("FAIL reset_state: acc=%h flags=%b done=%b err=%b, required 00 00000 0 0", acc, flags, done, err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (cmd_ready !== 1'b1 || operand_b !== 8'h00 || operation !== 4'h0) begin
         n_fail++; $display("FAIL reset_release: ready=%b b=%h op=%h, required 1 00 0", cmd_ready, operand_b, operation);
      end
      m_acc = 0; m_flags = 5'b00000;
   endtask

   task automatic test_directed();
      send_cmd(4'd0, 8'h7F, 1'b1, 1'b0);
      n_checks++;
      if (acc !== 8'h7F || flags !== 5'b00000) begin
         n_fail++; $display("FAIL dir_load: acc=%h flags=%b, required 7f 00000", acc, flags);
      end
      send_cmd(4'd0, 8'h01, 1'b0, 1'b0);
      n_checks++;
      if (acc !== 8'h80 || flags !== 5'b10100) begin
         n_fail++; $display("FAIL dir_add7f: acc=%h flags=%b, required 80 10100", acc, flags);
      end
      send_cmd(4'd0, 8'hFF, 1'b1, 1'b0);
      send_cmd(4'd0, 8'h01, 1'b0, 1'b0);
      n_checks++;
      if (acc !== 8'h00 || flags !== 5'b01111) begin
         n_fail++; $display("FAIL dir_addff: acc=%h flags=%b, required 00 01111", acc, flags);
      end
      send_cmd(4'd0, 8'h05, 1'b1, 1'b0);
      send_cmd(4'd1, 8'h07, 1'b0, 1'b0);
      n_checks++;
      if (acc !== 8'hFE || flags !== 5'b10001) begin
         n_fail++; $display("FAIL dir_sub: acc=%h flags=%b, required fe 10001", acc, flags);
      end
      send_cmd(4'd0, 8'h10, 1'b1, 1'b0);
      send_cmd(4'd3, 8'h00, 1'b0, 1'b0);
      n_checks++;
      if (acc !== 8'h10 || flags !== 5'b10001) begin
         n_fail++; $display("FAIL dir_div0: acc=%h flags=%b, required 10 10001", acc, flags);
      end
      send_cmd(4'd0, 8'h42, 1'b1, 1'b0);
      send_cmd(4'd15, 8'h42, 1'b0, 1'b0);
      n_checks++;
      if (acc !== 8'h42 || flags !== 5'b11001) begin
         n_fail++; $display("FAIL dir_cmp_eq: acc=%h flags=%b, required 42 11001", acc, flags);
      end
      reset_in_flight(0);
   endtask

   task automatic test_random();
      send_cmd(4'd0, 8'($urandom), 1'b1, 1'b0);
      for (int i = 0; i < 60; i++) begin
         send_cmd(4'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                  ($urandom_range(0, 4) == 0), 1'b0);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 20; i++) begin
         send_cmd(4'($urandom_range(0, 15)), 8'($urandom), ($urandom_range(0, 3) == 0), 1'b1);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      reset_in_flight(1);
      send_cmd(4'd0, 8'h3C, 1'b1, 1'b0);
      send_cmd(4'd2, 8'h10, 1'b0, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
